// File: rtl/mulmx_seq_ctrl.sv
// mulmx_seq_ctrl: walks (i,j) over an NxN matrix product and drives the A/B read and result write addresses.
// Optional feature macro MULMX_TRANSPOSE_EN adds transpose_b, which reads B as its transpose.
module mulmx_seq_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = $clog2(N*N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            ready,
`ifdef MULMX_TRANSPOSE_EN
    input  logic            transpose_b,
`endif
    output logic            en_mul,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   addr_r,
    output logic [N*AW-1:0] addr_a,
    output logic [N*AW-1:0] addr_b,
    output logic [AW-1:0]   row,
    output logic [AW-1:0]   col
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] NV   = AW'(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state;
    logic [AW-1:0] i_q;
    logic [AW-1:0] j_q;
    logic          trans_q;
    logic          run;

    // Sequencer: state plus row/column indices; abort wins over every RUN transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
`ifdef MULMX_TRANSPOSE_EN
            trans_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        i_q     <= '0;
                        j_q     <= '0;
`ifdef MULMX_TRANSPOSE_EN
                        trans_q <= transpose_b;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        i_q   <= '0;
                        j_q   <= '0;
                    end else if (ready) begin
                        if (j_q == LAST) begin
                            if (i_q == LAST) begin
                                state <= DONE;
                            end else begin
                                j_q <= '0;
                                i_q <= i_q + AW'(1);
                            end
                        end else begin
                            j_q <= j_q + AW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    i_q   <= '0;
                    j_q   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef MULMX_TRANSPOSE_EN
    assign trans_q = 1'b0;
`endif

    assign run    = (state == RUN);
    assign en_mul = run & ready;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign addr_r = run ? ((i_q * NV) + j_q) : '0;
    assign row    = run ? i_q : '0;
    assign col    = run ? j_q : '0;

    // One A/B address slice per inner-product term k
    for (genvar k = 0; k < int'(N); k++) begin : g_slice
        localparam logic [AW-1:0] KV = AW'(k);
        assign addr_a[k*AW +: AW] = run ? ((i_q * NV) + KV) : '0;
        assign addr_b[k*AW +: AW] = !run   ? '0 :
                                    trans_q ? ((j_q * NV) + KV) :
                                              ((KV * NV) + j_q);
    end

endmodule

// File: doc/mulmx_seq_ctrl.md
MULMX_SEQ_CTRL -- requirements
Module: mulmx_seq_ctrl

Interface
REQ-001 Parameter N, default 4: matrix dimension (NxN); legal range 2..16.
REQ-002 Parameter AW, default $clog2(N*N): element address width; SHALL NOT be overridden independently of N.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one full product sequence; sampled in IDLE only.
REQ-006 abort  input  1  terminate the running sequence.
REQ-007 ready  input  1  datapath ready; 0 stalls the sequence.
REQ-008 en_mul  output  1  current address set valid and accepted this cycle.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse after the last element is accepted.
REQ-011 addr_r  output  AW  result element address i*N+j.
REQ-012 addr_a  output  N*AW  slice k = matrix A read address i*N+k, k=0..N-1, slice 0 in LSBs.
REQ-013 addr_b  output  N*AW  slice k = matrix B read address k*N+j.
REQ-014 row, col  output  AW each  current indices i, j (zero-extended).

Function
REQ-015 FSM states: IDLE, RUN, DONE; encoding is implementer's choice.
REQ-016 IDLE -> RUN on clock edge with start=1; i, j cleared to 0 on that edge.
REQ-017 start SHALL be ignored while busy=1; no queuing.
REQ-018 In RUN, en_mul = ready; addresses are combinational from registered i, j.
REQ-019 In RUN with ready=1: j increments; at j=N-1, j wraps to 0 and i increments.
REQ-020 In RUN with ready=0: i, j, and all address outputs hold.
REQ-021 In RUN with ready=1 at i=j=N-1: next state DONE, i and j hold.
REQ-022 DONE lasts exactly one cycle: done=1, en_mul=0; then IDLE.
REQ-023 abort=1 in RUN or DONE: next state IDLE, no done pulse; abort has priority over ready and the last-element transition; abort in IDLE has no effect.
REQ-024 Minimum sequence: start at edge t, first en_mul cycle t+1, done in cycle t+N*N+1 with ready held high.
REQ-025 Outside RUN, addr_r, addr_a, addr_b, row, col SHALL drive 0 (never Z); en_mul=0.
REQ-026 Address arithmetic is unsigned, AW bits, no overflow for legal N.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, i=j=0, en_mul=busy=done=0, all addresses 0.
REQ-028 Reset mid-RUN abandons the sequence; no done pulse after release.
REQ-029 First start is accepted on the first rising edge with rst_n=1.

Configuration
REQ-030 Macro MULMX_TRANSPOSE_EN: when defined, an extra input transpose_b (1 bit) is present, sampled with start and latched for the whole sequence.
REQ-031 With MULMX_TRANSPOSE_EN and latched transpose_b=1, addr_b slice k = j*N+k (A x B-transpose); with transpose_b=0, behaviour is per REQ-013.
REQ-032 Without MULMX_TRANSPOSE_EN, the port does not exist and behaviour is per REQ-013 only.

Verification
REQ-033 N=4, ready=1, start pulse -> 16 en_mul cycles; cycle 1 addr_a={3,2,1,0}, addr_b={12,8,4,0}, addr_r=0; cycle 16 addr_a={15,14,13,12}, addr_b={15,11,7,3}, addr_r=15; done in cycle 17.
REQ-034 N=4, ready=0 for 3 cycles at addr_r=5 -> addr_r held at 5, en_mul=0 during stall, done delayed by 3 cycles.
REQ-035 abort at addr_r=9 -> IDLE next cycle, no done, outputs 0; a new start restarts at addr_r=0.
REQ-036 start asserted during RUN and in DONE cycle -> ignored; exactly one done pulse total.
REQ-037 rst_n low mid-sequence, asynchronous to clk -> outputs 0 immediately, no done pulse.
REQ-038 N=3, MULMX_TRANSPOSE_EN, transpose_b=1 -> element (1,2): addr_a={5,4,3}, addr_b={8,7,6}, addr_r=5; done after 9 accepted elements.
